mac_cfg_slave: RTL and testbench
================================

MAC_CFG_SLAVE -- requirements
Module: mac_cfg_slave

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 2, giving the number of stall cycles before acknowledge (range 0..15).
REQ-002 SHALL have parameter SWRST_CYCLES, default 64, giving the soft-reset hold duration in clk cycles (range 1..1023).
REQ-003 clk  in  1  system clock, all logic on rising edge.
REQ-004 nRST  in  1  reset, synchronous, active-low.
REQ-005 read  in  1  Avalon-MM read request, held by master until waitrequest low.
REQ-006 write  in  1  Avalon-MM write request, held by master until waitrequest low.
REQ-007 addr  in  8  register word address.
REQ-008 writedata  in  32  write data.
REQ-009 link_up  in  1  asynchronous PHY link indication.
REQ-010 readdata  out  32  read data, valid in acknowledge cycle.
REQ-011 waitrequest  out  1  high = stall; low for exactly one cycle per accepted transfer.
REQ-012 tx_ena, rx_ena, eth_speed, promis_en  out  1 each  decoded command_config bits 0, 1, 3, 4.
REQ-013 swrst_busy  out  1  high while soft reset in progress.

Function
REQ-014 FSM states SHALL be IDLE, STALL, ACK, SWRST.
- IDLE: waitrequest=1.
- read|write seen: latch addr/writedata/direction; go STALL, or ACK if WAIT_STATES=0.
REQ-015 STALL SHALL count WAIT_STATES cycles with waitrequest=1, then enter ACK.
REQ-016 ACK SHALL drive waitrequest=0 for one cycle.
- write committed at the end of this cycle.
- readdata valid during this cycle.
- next state IDLE, or SWRST if the write set command_config bit 13.
REQ-017 Request-to-acknowledge latency SHALL be WAIT_STATES+1 cycles.
- IDLE SHALL NOT re-accept in the cycle after ACK.
REQ-018 read and write asserted together SHALL be treated as a write; readdata=0.
REQ-019 Register map:
- 0x00: rev, RO 0x0000_0901.
- 0x01: scratch, RW.
- 0x02: command_config, RW, write mask 0x0002_227B.
- 0x3A: tx_cmd_stat, RW, 32-bit.
- 0x3B: rx_cmd_stat, RW, 32-bit.
- 0x81: phy_status, RO: bit2 = synced link_up, bit5 = synced link_up, others 0.
REQ-020 Unmapped addresses SHALL read 0, ignore writes, and still be acknowledged.
REQ-021 Unmasked command_config bits SHALL read 0.
REQ-022 readdata SHALL be 0 outside ACK.
REQ-023 SWRST SHALL hold swrst_busy=1 and force tx_ena/rx_ena outputs to 0 for SWRST_CYCLES cycles.
- command_config bit 13 reads 1 during SWRST.
- on exit, bit 13 clears; other config bits are retained.
- return to IDLE.
REQ-024 Requests arriving during SWRST SHALL stall (waitrequest=1).
- accepted in IDLE after SWRST ends.
- full latency applies from that point.
REQ-025 link_up SHALL pass through a two-flop synchronizer before use (2-cycle latency).
REQ-026 The SWRST counter SHALL be 10 bits and SHALL NOT wrap; exit occurs on terminal count.

Reset
REQ-027 nRST low SHALL force on the next edge:
- state=IDLE, waitrequest=1, readdata=0.
- all RW registers=0, counters=0, synchronizer=0.
- config outputs=0, swrst_busy=0.
REQ-028 Reset asserted mid-STALL, ACK or SWRST SHALL abort the transfer with no register update.

Structure
REQ-029 Package mac_cfg_pkg SHALL hold:
- register addresses.
- command_config bit positions and write mask.
- rev constant.
- FSM state encoding.
REQ-030 Sub-module sync2 (two-flop synchronizer) SHALL be instantiated for link_up; everything else stays in mac_cfg_slave.

Verification
REQ-031 Write 0x0000_001B to 0x02, WAIT_STATES=2 -> waitrequest low on cycle 3; tx_ena=rx_ena=eth_speed=promis_en=1 next cycle.
REQ-032 Read 0x02 after REQ-031 -> readdata 0x0000_001B in the ack cycle; 0 otherwise.
REQ-033 Write 0x0000_2003 to 0x02 -> swrst_busy=1 for 64 cycles, tx_ena=rx_ena=0; then reads 0x0000_0003, outputs restored.
REQ-034 Read 0x02 issued during SWRST -> waitrequest held high until SWRST ends plus 3 cycles; data correct.
REQ-035 Write 0xDEAD_BEEF to 0x55 then read it -> both acknowledged; read returns 0.
REQ-036 link_up=1, read 0x81 -> 0x0000_0024; nRST mid-STALL of a write to 0x01 -> scratch reads 0.

Source files
------------

// File: rtl/mac_cfg_pkg.sv
// rtl/mac_cfg_pkg.sv - register map, command_config layout and FSM encoding for mac_cfg_slave
package mac_cfg_pkg;

  localparam logic [7:0] ADDR_REV         = 8'h00;
  localparam logic [7:0] ADDR_SCRATCH     = 8'h01;
  localparam logic [7:0] ADDR_CMD_CFG     = 8'h02;
  localparam logic [7:0] ADDR_TX_CMD_STAT = 8'h3A;
  localparam logic [7:0] ADDR_RX_CMD_STAT = 8'h3B;
  localparam logic [7:0] ADDR_PHY_STATUS  = 8'h81;

  localparam logic [31:0] REV_VALUE     = 32'h0000_0901;
  localparam logic [31:0] CMD_CFG_WMASK = 32'h0002_227B;

  localparam int CFG_TX_ENA    = 0;
  localparam int CFG_RX_ENA    = 1;
  localparam int CFG_ETH_SPEED = 3;
  localparam int CFG_PROMIS_EN = 4;
  localparam int CFG_SW_RESET  = 13;

  localparam int PHY_LINK_A = 2;
  localparam int PHY_LINK_B = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STALL = 2'd1,
    ST_ACK   = 2'd2,
    ST_SWRST = 2'd3
  } state_t;

  // The link indication is mirrored into two status bits; everything else reads 0.
  function automatic logic [31:0] phy_status_word(input logic link);
    logic [31:0] w;
    w             = 32'h0;
    w[PHY_LINK_A] = link;
    w[PHY_LINK_B] = link;
    return w;
  endfunction

endpackage

// File: rtl/mac_cfg_slave_sync2.sv
// rtl/mac_cfg_slave_sync2.sv - two-flop synchronizer for asynchronous single-bit inputs
module sync2 (
  input  logic clk,
  input  logic nRST,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // First flop may go metastable; second flop gives a settled copy.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/mac_cfg_slave.sv
// rtl/mac_cfg_slave.sv - Avalon-MM configuration slave with wait states and soft reset
import mac_cfg_pkg::*;

module mac_cfg_slave #(
  parameter int WAIT_STATES  = 2,
  parameter int SWRST_CYCLES = 64
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        read,
  input  logic        write,
  input  logic [7:0]  addr,
  input  logic [31:0] writedata,
  input  logic        link_up,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic        tx_ena,
  output logic        rx_ena,
  output logic        eth_speed,
  output logic        promis_en,
  output logic        swrst_busy
);

  localparam logic [3:0] WAIT_LAST  = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);
  localparam logic [9:0] SWRST_LAST = 10'(SWRST_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_wait_cnt;
  logic [9:0]  r_swrst_cnt;
  logic [7:0]  r_addr;
  logic [31:0] r_wdata;
  logic        r_is_wr;
  logic        r_ack_d;
  logic [31:0] r_scratch;
  logic [31:0] r_cfg;
  logic [31:0] r_tx_cmd;
  logic [31:0] r_rx_cmd;
  logic        w_link;
  logic        w_accept;
  logic        w_swrst_req;
  logic [31:0] w_rdata;

  sync2 u_link_sync (
    .clk  (clk),
    .nRST (nRST),
    .i_d  (link_up),
    .o_q  (w_link)
  );

  // A request is taken only in IDLE, and never in the cycle straight after an acknowledge.
  assign w_accept    = (r_state == ST_IDLE) && (read || write) && !r_ack_d;
  assign w_swrst_req = r_is_wr && (r_addr == ADDR_CMD_CFG) && r_wdata[CFG_SW_RESET];

  // State register.
  always_ff @(posedge clk) begin
    if (!nRST) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = (WAIT_STATES == 0) ? ST_ACK : ST_STALL;
      ST_STALL: if (r_wait_cnt == WAIT_LAST) w_next = ST_ACK;
      ST_ACK:   w_next = w_swrst_req ? ST_SWRST : ST_IDLE;
      ST_SWRST: if (r_swrst_cnt == SWRST_LAST) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Request latch, wait-state counter and soft-reset counter.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_is_wr     <= 1'b0;
      r_wait_cnt  <= '0;
      r_swrst_cnt <= '0;
      r_ack_d     <= 1'b0;
    end else begin
      r_ack_d <= (r_state == ST_ACK);
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr     <= addr;
            r_wdata    <= writedata;
            r_is_wr    <= write;
            r_wait_cnt <= '0;
          end
        end
        ST_STALL: begin
          if (r_wait_cnt != WAIT_LAST) r_wait_cnt <= r_wait_cnt + 4'd1;
        end
        ST_ACK: begin
          r_swrst_cnt <= '0;
        end
        ST_SWRST: begin
          // Saturates at terminal count instead of wrapping.
          if (r_swrst_cnt != SWRST_LAST) r_swrst_cnt <= r_swrst_cnt + 10'd1;
        end
        default: ;
      endcase
    end
  end

  // Register file: writes commit at the end of ACK; soft-reset exit clears the self-clearing bit.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      r_scratch <= '0;
      r_cfg     <= '0;
      r_tx_cmd  <= '0;
      r_rx_cmd  <= '0;
    end else if (r_state == ST_ACK && r_is_wr) begin
      case (r_addr)
        ADDR_SCRATCH:     r_scratch <= r_wdata;
        ADDR_CMD_CFG:     r_cfg     <= r_wdata & CMD_CFG_WMASK;
        ADDR_TX_CMD_STAT: r_tx_cmd  <= r_wdata;
        ADDR_RX_CMD_STAT: r_rx_cmd  <= r_wdata;
        default: ;
      endcase
    end else if (r_state == ST_SWRST && r_swrst_cnt == SWRST_LAST) begin
      r_cfg[CFG_SW_RESET] <= 1'b0;
    end
  end

  // Read mux; data only leaves the block in the acknowledge cycle of a pure read.
  always_comb begin
    w_rdata = 32'h0;
    case (r_addr)
      ADDR_REV:         w_rdata = REV_VALUE;
      ADDR_SCRATCH:     w_rdata = r_scratch;
      ADDR_CMD_CFG:     w_rdata = r_cfg;
      ADDR_TX_CMD_STAT: w_rdata = r_tx_cmd;
      ADDR_RX_CMD_STAT: w_rdata = r_rx_cmd;
      ADDR_PHY_STATUS:  w_rdata = phy_status_word(w_link);
      default:          w_rdata = 32'h0;
    endcase
    readdata = (r_state == ST_ACK && !r_is_wr) ? w_rdata : 32'h0;
  end

  assign waitrequest = (r_state != ST_ACK);
  assign swrst_busy  = (r_state == ST_SWRST);
  assign tx_ena      = r_cfg[CFG_TX_ENA] & ~swrst_busy;
  assign rx_ena      = r_cfg[CFG_RX_ENA] & ~swrst_busy;
  assign eth_speed   = r_cfg[CFG_ETH_SPEED];
  assign promis_en   = r_cfg[CFG_PROMIS_EN];

endmodule

// File: tb/tb_mac_cfg_slave.sv
// tb/tb_mac_cfg_slave.sv - directed self-checking bench for mac_cfg_slave
module tb_mac_cfg_slave;

  logic        clk;
  logic        nRST;
  logic        read;
  logic        write;
  logic [7:0]  addr;
  logic [31:0] writedata;
  logic        link_up;
  logic [31:0] readdata;
  logic        waitrequest;
  logic        tx_ena;
  logic        rx_ena;
  logic        eth_speed;
  logic        promis_en;
  logic        swrst_busy;

  int tests_run;
  int tests_failed;

  mac_cfg_slave #(.WAIT_STATES(2), .SWRST_CYCLES(64)) dut (
    .clk         (clk),
    .nRST        (nRST),
    .read        (read),
    .write       (write),
    .addr        (addr),
    .writedata   (writedata),
    .link_up     (link_up),
    .readdata    (readdata),
    .waitrequest (waitrequest),
    .tx_ena      (tx_ena),
    .rx_ena      (rx_ena),
    .eth_speed   (eth_speed),
    .promis_en   (promis_en),
    .swrst_busy  (swrst_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One bus transfer: lat = stalled cycles before the ack (-1 on timeout), stray = nonzero readdata while stalled.
  task automatic bus_xfer(input logic do_wr, input logic do_rd, input logic [7:0] a,
                          input logic [31:0] d, output int lat, output logic [31:0] rd,
                          output int stray);
    bit done;
    @(posedge clk); #1;
    write = do_wr; read = do_rd; addr = a; writedata = d;
    lat = 0; stray = 0; rd = 32'h0; done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!waitrequest) begin
        rd = readdata;
        done = 1;
      end else begin
        lat++;
        if (readdata !== 32'h0) stray++;
      end
    end
    if (!done) lat = -1;
    @(posedge clk); #1;
    write = 1'b0; read = 1'b0;
  endtask

  task automatic test_reset;
    int lat, stray;
    logic [31:0] rd;
    nRST = 1'b0; read = 1'b0; write = 1'b0; addr = 8'h0; writedata = 32'h0; link_up = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (waitrequest !== 1'b1 || readdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_bus: waitrequest=%b readdata=%h required 1/00000000", waitrequest, readdata);
    end
    tests_run++;
    if ({tx_ena, rx_ena, eth_speed, promis_en, swrst_busy} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b required 00000", {tx_ena, rx_ena, eth_speed, promis_en, swrst_busy});
    end
    @(posedge clk); #1; nRST = 1'b1;
    bus_xfer(1'b0, 1'b1, 8'h00, 32'h0, lat, rd, stray);
    tests_run++;
    if (rd !== 32'h0000_0901 || lat != 3) begin
      tests_failed++;
      $display("FAIL rev_read: data=%h lat=%0d required 00000901 lat=3", rd, lat);
    end
  endtask

  task automatic test_cfg_write;
    int lat, stray;
    logic [31:0] rd;
    bus_xfer(1'b1, 1'b0, 8'h02, 32'h0000_001B, lat, rd, stray);
    tests_run++;
    if (lat != 3 || rd !== 32'h0) begin
      tests_failed++;
      $display("FAIL cfg_write_ack: lat=%0d readdata=%h required lat=3 data=0", lat, rd);
    end
    @(negedge clk);
    tests_run++;
    if ({tx_ena, rx_ena, eth_speed, promis_en} !== 4'b1111) begin
      tests_failed++;
      $display("FAIL cfg_outputs: got %b required 1111", {tx_ena, rx_ena, eth_speed, promis_en});
    end
  endtask

  task automatic test_cfg_read;
    int lat, stray;
    logic [31:0] rd;
    bus_xfer(1'b0, 1'b1, 8'h02, 32'h0, lat, rd, stray);
    tests_run++;
    if (rd !== 32'h0000_001B || lat != 3 || stray != 0) begin
      tests_failed++;
      $display("FAIL cfg_read: data=%h lat=%0d stray=%0d required 0000001b lat=3 stray=0", rd, lat, stray);
    end
    @(negedge clk);
    tests_run++;
    if (readdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL readdata_idle: got %h required 00000000", readdata);
    end
  endtask

  task automatic test_rw_regs;
    int lat, stray;
    logic [31:0] rd;
    logic [7:0]  a_tab [3] = '{8'h01, 8'h3A, 8'h3B};
    logic [31:0] d_tab [3] = '{32'hA5A5_5A5A, 32'hFFFF_FFFF, 32'h1234_5678};
    for (int i = 0; i < 3; i++) begin
      bus_xfer(1'b1, 1'b0, a_tab[i], d_tab[i], lat, rd, stray);
      bus_xfer(1'b0, 1'b1, a_tab[i], 32'h0, lat, rd, stray);
      tests_run++;
      if (rd !== d_tab[i]) begin
        tests_failed++;
        $display("FAIL rw_reg_%h: got %h required %h", a_tab[i], rd, d_tab[i]);
      end
    end
  endtask

  task automatic test_cfg_mask;
    int lat, stray;
    logic [31:0] rd;
    bus_xfer(1'b1, 1'b0, 8'h02, 32'hFFFF_DFFF, lat, rd, stray);
    bus_xfer(1'b0, 1'b1, 8'h02, 32'h0, lat, rd, stray);
    tests_run++;
    if (rd !== 32'h0002_027B || swrst_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL cfg_mask: data=%h busy=%b required 0002027b busy=0", rd, swrst_busy);
    end
  endtask

  task automatic test_swrst;
    int lat, stray, busy_n, ena_viol;
    logic [31:0] rd;
    bus_xfer(1'b1, 1'b0, 8'h02, 32'h0000_2003, lat, rd, stray);
    busy_n = 0; ena_viol = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (swrst_busy === 1'b1) begin
        busy_n++;
        if (tx_ena !== 1'b0 || rx_ena !== 1'b0) ena_viol++;
      end else if (busy_n > 0) begin
        break;
      end
    end
    tests_run++;
    if (busy_n != 64 || ena_viol != 0) begin
      tests_failed++;
      $display("FAIL swrst_hold: busy_cycles=%0d ena_violations=%0d required 64/0", busy_n, ena_viol);
    end
    bus_xfer(1'b0, 1'b1, 8'h02, 32'h0, lat, rd, stray);
    tests_run++;
    if (rd !== 32'h0000_0003) begin
      tests_failed++;
      $display("FAIL swrst_cfg_after: got %h required 00000003", rd);
    end
    @(negedge clk);
    tests_run++;
    if ({tx_ena, rx_ena, eth_speed, promis_en} !== 4'b1100) begin
      tests_failed++;
      $display("FAIL swrst_outputs: got %b required 1100", {tx_ena, rx_ena, eth_speed, promis_en});
    end
  endtask

  task automatic test_read_during_swrst;
    int lat, stray, busy_n, viol, post;
    logic [31:0] rd;
    bit done;
    bus_xfer(1'b1, 1'b0, 8'h02, 32'h0000_2003, lat, rd, stray);
    @(posedge clk); #1;
    read = 1'b1; addr = 8'h02;
    busy_n = 0; viol = 0; post = 0; done = 0; rd = 32'h0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (swrst_busy === 1'b1) begin
        busy_n++;
        if (waitrequest !== 1'b1) viol++;
      end else if (waitrequest === 1'b1) begin
        post++;
      end else begin
        rd = readdata;
        done = 1;
      end
    end
    @(posedge clk); #1;
    read = 1'b0;
    tests_run++;
    if (!done || viol != 0 || busy_n == 0 || post != 3 || rd !== 32'h0000_0003) begin
      tests_failed++;
      $display("FAIL read_in_swrst: done=%0d viol=%0d busy=%0d post=%0d data=%h required 1/0/>0/3/00000003",
               done, viol, busy_n, post, rd);
    end
  endtask

  task automatic test_unmapped;
    int lat_w, lat_r, stray;
    logic [31:0] rd;
    bus_xfer(1'b1, 1'b0, 8'h55, 32'hDEAD_BEEF, lat_w, rd, stray);
    bus_xfer(1'b0, 1'b1, 8'h55, 32'h0, lat_r, rd, stray);
    tests_run++;
    if (lat_w != 3 || lat_r != 3 || rd !== 32'h0) begin
      tests_failed++;
      $display("FAIL unmapped: lat_w=%0d lat_r=%0d data=%h required 3/3/00000000", lat_w, lat_r, rd);
    end
  endtask

  task automatic test_read_write_both;
    int lat, stray;
    logic [31:0] rd;
    bus_xfer(1'b1, 1'b1, 8'h01, 32'h0BAD_F00D, lat, rd, stray);
    tests_run++;
    if (rd !== 32'h0 || lat != 3) begin
      tests_failed++;
      $display("FAIL rw_both_ack: data=%h lat=%0d required 00000000 lat=3", rd, lat);
    end
    bus_xfer(1'b0, 1'b1, 8'h01, 32'h0, lat, rd, stray);
    tests_run++;
    if (rd !== 32'h0BAD_F00D) begin
      tests_failed++;
      $display("FAIL rw_both_commit: got %h required 0badf00d", rd);
    end
  endtask

  task automatic test_phy_status;
    int lat, stray;
    logic [31:0] rd;
    bus_xfer(1'b0, 1'b1, 8'h81, 32'h0, lat, rd, stray);
    tests_run++;
    if (rd !== 32'h0) begin
      tests_failed++;
      $display("FAIL phy_link_down: got %h required 00000000", rd);
    end
    link_up = 1'b1;
    repeat (3) @(posedge clk);
    bus_xfer(1'b0, 1'b1, 8'h81, 32'h0, lat, rd, stray);
    tests_run++;
    if (rd !== 32'h0000_0024) begin
      tests_failed++;
      $display("FAIL phy_link_up: got %h required 00000024", rd);
    end
  endtask

  task automatic test_back_to_back;
    int lat1, lat2;
    logic [31:0] rd1, rd2;
    bit done;
    @(posedge clk); #1;
    read = 1'b1; addr = 8'h00;
    lat1 = 0; lat2 = 0; done = 0; rd1 = 32'h0; rd2 = 32'h0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (!waitrequest) begin rd1 = readdata; done = 1; end else lat1++;
    end
    @(posedge clk); #1;
    addr = 8'h01;
    done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (!waitrequest) begin rd2 = readdata; done = 1; end else lat2++;
    end
    @(posedge clk); #1;
    read = 1'b0;
    tests_run++;
    if (lat1 != 3 || lat2 != 4 || rd1 !== 32'h0000_0901 || rd2 !== 32'h0BAD_F00D) begin
      tests_failed++;
      $display("FAIL back_to_back: lat1=%0d lat2=%0d d1=%h d2=%h required 3/4/00000901/0badf00d",
               lat1, lat2, rd1, rd2);
    end
  endtask

  task automatic test_reset_mid_stall;
    int lat, stray;
    logic [31:0] rd;
    @(posedge clk); #1;
    write = 1'b1; addr = 8'h01; writedata = 32'h1234_5678;
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (waitrequest !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_stall_state: waitrequest=%b required 1", waitrequest);
    end
    #1 nRST = 1'b0;
    @(posedge clk); #1;
    write = 1'b0;
    @(posedge clk); #1;
    nRST = 1'b1;
    bus_xfer(1'b0, 1'b1, 8'h01, 32'h0, lat, rd, stray);
    tests_run++;
    if (rd !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_mid_stall_scratch: got %h required 00000000", rd);
    end
    bus_xfer(1'b0, 1'b1, 8'h02, 32'h0, lat, rd, stray);
    tests_run++;
    if (rd !== 32'h0 || {tx_ena, rx_ena, eth_speed, promis_en} !== 4'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_stall_cfg: data=%h outs=%b required 00000000/0000",
               rd, {tx_ena, rx_ena, eth_speed, promis_en});
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_cfg_write();
    test_cfg_read();
    test_rw_regs();
    test_cfg_mask();
    test_swrst();
    test_read_during_swrst();
    test_unmapped();
    test_read_write_both();
    test_phy_status();
    test_back_to_back();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
